rd_fwft_buf: RTL and testbench

- Read-side output stage sitting directly downstream of the async FIFO read controller and dual-port RAM, in the read clock domain.
- Pops words from the FIFO (drives rinc, watches rempty, samples RAM read data at the current read address).
- Presents them on a first-word-fall-through valid/ready interface through a 2-entry registered buffer (output register plus skid register).
- Provides full throughput while keeping dout_ready off every combinational path to rinc.

---
 rtl/rd_fwft_buf.sv | 115 +++++++++++
 tb/tb_rd_fwft_buf.sv | 135 +++++++++++++
 2 files changed

// File: rtl/rd_fwft_buf.sv
// Read-side first-word-fall-through stage for the async FIFO.
// A 2-entry buffer (output register plus skid register) keeps dout_ready out of the rinc path.
module rd_fwft_buf #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic                  rempty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic [1:0]            level
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [DATA_WIDTH-1:0] skid;
  logic [DATA_WIDTH-1:0] dout_next;
  logic [DATA_WIDTH-1:0] skid_next;
  logic                  push;
  logic                  pop;

  // Pop request depends only on registered state and rempty, never on dout_ready.
  assign rinc = ~rempty & (state != TWO) & ~rrst;
  assign push = rinc;
  assign pop  = dout_valid & dout_ready;

  // State register, output register and skid register.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      state <= EMPTY;
      dout  <= {DATA_WIDTH{1'b0}};
      skid  <= {DATA_WIDTH{1'b0}};
    end else begin
      state <= state_next;
      dout  <= dout_next;
      skid  <= skid_next;
    end
  end

  // Next-state and data-path selection.
  always_comb begin
    state_next = state;
    dout_next  = dout;
    skid_next  = skid;
    case (state)
      EMPTY: begin
        if (push) begin
          state_next = ONE;
          dout_next  = rdata;
        end else begin
          state_next = EMPTY;
        end
      end
      ONE: begin
        if (push && pop) begin
          state_next = ONE;
          dout_next  = rdata;
        end else if (push) begin
          state_next = TWO;
          skid_next  = rdata;
        end else if (pop) begin
          state_next = EMPTY;
        end else begin
          state_next = ONE;
        end
      end
      TWO: begin
        if (pop) begin
          state_next = ONE;
          dout_next  = skid;
        end else begin
          state_next = TWO;
        end
      end
      default: begin
        // Unreachable encoding recovers to a clean empty buffer.
        state_next = EMPTY;
      end
    endcase
  end

  // Status outputs decoded from registered state only.
  always_comb begin
    dout_valid = 1'b0;
    level      = 2'd0;
    case (state)
      EMPTY: begin
        dout_valid = 1'b0;
        level      = 2'd0;
      end
      ONE: begin
        dout_valid = 1'b1;
        level      = 2'd1;
      end
      TWO: begin
        dout_valid = 1'b1;
        level      = 2'd2;
      end
      default: begin
        dout_valid = 1'b0;
        level      = 2'd0;
      end
    endcase
  end

endmodule

// File: tb/tb_rd_fwft_buf.sv
// Self-checking bench for rd_fwft_buf: a source queue stands in for the FIFO,
// and a scoreboard queue holds the words expected inside the buffer, in order.
module tb_rd_fwft_buf;

  logic        rclk;
  logic        rrst;
  logic        rempty;
  logic [31:0] rdata;
  logic        rinc;
  logic [31:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic [1:0]  level;

  logic [31:0] src[$];
  logic [31:0] sb[$];
  int          total;
  int          passed;

  rd_fwft_buf #(.DATA_WIDTH(32)) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .rempty     (rempty),
    .rdata      (rdata),
    .rinc       (rinc),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .level      (level)
  );

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One clock cycle, entered and left at a falling edge.
  task automatic tick();
    logic push_m;
    logic pop_m;
    rempty = (src.size() == 0);
    rdata  = rempty ? 32'hDEAD_BEEF : src[0];
    #1;
    push_m = (src.size() != 0) && (sb.size() < 2);
    pop_m  = (sb.size() != 0) && dout_ready;
    check("rinc", 32'(rinc), 32'(push_m));
    check("level", 32'(level), 32'(sb.size()));
    check("dout_valid", 32'(dout_valid), 32'(sb.size() != 0));
    if (sb.size() != 0) check("dout", dout, sb[0]);
    @(posedge rclk);
    if (pop_m) void'(sb.pop_front());
    if (push_m) sb.push_back(src.pop_front());
    @(negedge rclk);
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    rrst       = 1'b1;
    rempty     = 1'b0;
    rdata      = 32'h1234_5678;
    dout_ready = 1'b0;

    // 1. Reset holds everything idle even with data available.
    repeat (2) @(negedge rclk);
    #1;
    check("rst_rinc", 32'(rinc), 32'd0);
    check("rst_valid", 32'(dout_valid), 32'd0);
    check("rst_dout", dout, 32'd0);
    check("rst_level", 32'(level), 32'd0);
    @(negedge rclk);
    rrst = 1'b0;
    repeat (3) tick();

    // 2. Fall-through latency of one cycle.
    dout_ready = 1'b1;
    src.push_back(32'hA5A5_0001);
    tick();
    rempty = 1'b1;
    #1;
    check("lat_valid", 32'(dout_valid), 32'd1);
    check("lat_dout", dout, 32'hA5A5_0001);
    check("lat_level", 32'(level), 32'd1);
    repeat (2) tick();

    // 3. Streaming 16 words at full rate.
    for (int i = 0; i < 16; i++) src.push_back(32'(i));
    repeat (18) tick();

    // 4. Backpressure fills the skid, then drains in order.
    dout_ready = 1'b0;
    for (int i = 16; i < 20; i++) src.push_back(32'(i));
    repeat (4) tick();
    check("bp_level", 32'(level), 32'd2);
    check("bp_src_left", 32'(src.size()), 32'd2);
    dout_ready = 1'b1;
    repeat (6) tick();

    // 5. Alternating ready over 8 words.
    for (int i = 0; i < 8; i++) src.push_back(32'h20 + 32'(i));
    for (int i = 0; i < 20; i++) begin
      dout_ready = ~dout_ready;
      tick();
    end
    check("tog_drained", 32'(sb.size() + src.size()), 32'd0);

    // 6. Asynchronous reset between edges discards a full buffer.
    dout_ready = 1'b0;
    for (int i = 0; i < 4; i++) src.push_back(32'h40 + 32'(i));
    repeat (3) tick();
    check("mr_level_pre", 32'(level), 32'd2);
    rempty = 1'b0;
    rdata  = src[0];
    #2 rrst = 1'b1;
    #1;
    check("mr_valid", 32'(dout_valid), 32'd0);
    check("mr_level", 32'(level), 32'd0);
    check("mr_rinc", 32'(rinc), 32'd0);
    check("mr_dout", dout, 32'd0);
    sb.delete();
    @(negedge rclk);
    check("mr_no_pop", 32'(level), 32'd0);
    rrst       = 1'b0;
    dout_ready = 1'b1;
    repeat (5) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
